// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 scanning multiplexer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mux_pkg;

    // Width of the dwell input and of the per-channel hold counter.
    localparam int DWELL_W = 8;

    // The operating mode doubles as the FSM state encoding.
    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/mux_scan_ctr.sv
// Channel sequencer for SCAN mode: hold counter, channel pointer, wrap pulse.
// Latency: pointer is presented combinationally; wrap is registered to line up with the top's output registers.
// Backpressure: none; only advances on i_step, holding all state otherwise.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_step,
    input  logic               i_restart,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [SW-1:0]      o_ptr,
    output logic               o_wrap
);

    localparam logic [SW-1:0]      LAST    = SW'(N - 1);
    localparam logic [SW-1:0]      PTR_ONE = SW'(1);
    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    logic [SW-1:0]      r_ptr;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_pend;
    logic               r_wrap;

    logic [SW-1:0]      w_cur_ptr;
    logic [DWELL_W-1:0] w_cur_cnt;
    logic               w_cur_pend;
    logic               w_advance;

    // Entering SCAN from DIRECT starts from a clean channel 0 regardless of leftover state.
    assign w_cur_ptr  = i_restart ? '0   : r_ptr;
    assign w_cur_cnt  = i_restart ? '0   : r_cnt;
    assign w_cur_pend = i_restart ? 1'b0 : r_pend;
    // dwell is compared live, so a shrinking dwell releases the channel immediately.
    assign w_advance  = (w_cur_cnt >= i_dwell);

    assign o_ptr  = w_cur_ptr;
    assign o_wrap = r_wrap;

    // Step the hold counter and pointer; r_pend marks that pointer 0 was reached by wrapping from N-1,
    // so the wrap pulse fires together with the first output sampled from channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_step) begin
                r_wrap <= w_cur_pend;
                if (w_advance) begin
                    r_cnt  <= '0;
                    r_ptr  <= (w_cur_ptr == LAST) ? '0 : (w_cur_ptr + PTR_ONE);
                    r_pend <= (w_cur_ptr == LAST);
                end else begin
                    r_cnt  <= w_cur_cnt + CNT_ONE;
                    r_ptr  <= w_cur_ptr;
                    r_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mux_n1_scan.sv
// N:1 multiplexer with direct select or automatic round-robin scan with per-channel dwell.
// Latency: one cycle from sel/scan pointer to registered y/ch/y_valid.
// Backpressure: none; en=0 freezes data, channel, counter and FSM and drops the strobes.
module mux_n1_scan
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [N*W-1:0]     a,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]       y,
    output logic               y_valid,
    output logic [SW-1:0]      ch,
    output logic               sel_err,
    output logic               wrap
);

    localparam logic [SW:0] N_EXT = (SW + 1)'(N);

    mode_e         r_state;
    logic [W-1:0]  r_y;
    logic          r_y_valid;
    logic [SW-1:0] r_ch;
    logic          r_sel_err;

    logic [W-1:0]  w_chan [N];
    logic [SW-1:0] w_scan_ptr;
    logic          w_step;
    logic          w_restart;
    logic          w_sel_ok;

    // Unpack the channel bus so selection is a plain array lookup.
    for (genvar k = 0; k < N; k++) begin : g_chan
        assign w_chan[k] = a[k*W +: W];
    end

    assign w_step    = en & mode;
    assign w_restart = (r_state == DIRECT);
    assign w_sel_ok  = ({1'b0, sel} < N_EXT);

    mux_scan_ctr #(
        .N (N)
    ) u_scan_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_step    (w_step),
        .i_restart (w_restart),
        .i_dwell   (dwell),
        .o_ptr     (w_scan_ptr),
        .o_wrap    (wrap)
    );

    // Mode FSM plus output registers; the mode sampled at an enabled edge decides both the next state
    // and which path (sel or scan pointer) feeds the outputs at that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIRECT;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_ch      <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            r_sel_err <= 1'b0;
            if (en) begin
                r_state <= mode ? SCAN : DIRECT;
                if (mode) begin
                    r_y       <= w_chan[w_scan_ptr];
                    r_ch      <= w_scan_ptr;
                    r_y_valid <= 1'b1;
                end else if (w_sel_ok) begin
                    r_y       <= w_chan[sel];
                    r_ch      <= sel;
                    r_y_valid <= 1'b1;
                end else begin
                    // Out-of-range select: flag it, blank the data, keep the last good channel.
                    r_y       <= '0;
                    r_sel_err <= 1'b1;
                end
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign ch      = r_ch;
    assign sel_err = r_sel_err;

endmodule

// File: tb/tb_mux_n1_scan.sv
module tb_mux_n1_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] dwell;

    logic [7:0] a8 = 8'b01001101;
    logic       y8, y_valid8, sel_err8, wrap8;
    logic [2:0] ch8;

    logic [5:0] a6 = 6'b110110;
    logic       y6, y_valid6, sel_err6, wrap6;
    logic [2:0] ch6;

    int n_pass  = 0;
    int n_total = 0;

    // Hand-computed channel values for a8 = 8'b01001101, channel 0 first.
    logic exp_ch8 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mux_n1_scan #(.N(8), .W(1)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .a       (a8),
        .dwell   (dwell),
        .y       (y8),
        .y_valid (y_valid8),
        .ch      (ch8),
        .sel_err (sel_err8),
        .wrap    (wrap8)
    );

    mux_n1_scan #(.N(6), .W(1)) dut6 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .a       (a6),
        .dwell   (dwell),
        .y       (y6),
        .y_valid (y_valid6),
        .ch      (ch6),
        .sel_err (sel_err6),
        .wrap    (wrap6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic y_e, input logic v_e, input logic [2:0] ch_e,
                        input logic err_e, input logic wrap_e);
        chk({tag, ".y"},       {31'd0, y8},       {31'd0, y_e});
        chk({tag, ".y_valid"}, {31'd0, y_valid8}, {31'd0, v_e});
        chk({tag, ".ch"},      {29'd0, ch8},      {29'd0, ch_e});
        chk({tag, ".sel_err"}, {31'd0, sel_err8}, {31'd0, err_e});
        chk({tag, ".wrap"},    {31'd0, wrap8},    {31'd0, wrap_e});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0; dwell = 8'd0;

        // Reset state
        step();
        chk8("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // DIRECT sweep over every channel
        rst = 1'b0; en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            chk8($sformatf("direct%0d", s), exp_ch8[s], 1'b1, 3'(s), 1'b0, 1'b0);
        end

        // SCAN with dwell=0: one channel per cycle, wrap on the return to channel 0
        mode = 1'b1; dwell = 8'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk8($sformatf("scan_d0_%0d", i), exp_ch8[i % 8], 1'b1, 3'(i % 8), 1'b0, (i == 8));
        end

        // Back to DIRECT for one cycle, then SCAN with dwell=2 restarts at channel 0
        mode = 1'b0; sel = 3'd6;
        step();
        chk8("direct_gap", 1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
        mode = 1'b1; dwell = 8'd2;
        for (int i = 0; i < 9; i++) begin
            step();
            chk8($sformatf("scan_d2_%0d", i), exp_ch8[i / 3], 1'b1, 3'(i / 3), 1'b0, 1'b0);
        end
        step();
        chk8("scan_d2_ch3_first", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);

        // Enable hold at channel 3 with one dwell cycle already spent
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk8($sformatf("hold%0d", i), 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
        end
        en = 1'b1;
        step();
        chk8("resume_ch3_a", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        step();
        chk8("resume_ch3_b", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        step();
        chk8("resume_ch4", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        step();
        step();
        step();
        chk8("scan_ch5", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);

        // Reset mid-scan, then restart the scan from channel 0
        rst = 1'b1;
        step();
        chk8("rst_mid", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk8("rst_restart0", 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        step();
        chk8("rst_restart0b", 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);

        // N=6 instance: valid select, out-of-range selects, then last valid channel
        mode = 1'b0; sel = 3'd2;
        step();
        chk("n6_sel2.y",       {31'd0, y6},       32'd1);
        chk("n6_sel2.y_valid", {31'd0, y_valid6}, 32'd1);
        chk("n6_sel2.ch",      {29'd0, ch6},      32'd2);
        chk("n6_sel2.sel_err", {31'd0, sel_err6}, 32'd0);
        sel = 3'd7;
        step();
        chk("n6_sel7.y",       {31'd0, y6},       32'd0);
        chk("n6_sel7.y_valid", {31'd0, y_valid6}, 32'd0);
        chk("n6_sel7.ch",      {29'd0, ch6},      32'd2);
        chk("n6_sel7.sel_err", {31'd0, sel_err6}, 32'd1);
        sel = 3'd6;
        step();
        chk("n6_sel6.y_valid", {31'd0, y_valid6}, 32'd0);
        chk("n6_sel6.ch",      {29'd0, ch6},      32'd2);
        chk("n6_sel6.sel_err", {31'd0, sel_err6}, 32'd1);
        sel = 3'd5;
        step();
        chk("n6_sel5.y",       {31'd0, y6},       32'd1);
        chk("n6_sel5.y_valid", {31'd0, y_valid6}, 32'd1);
        chk("n6_sel5.ch",      {29'd0, ch6},      32'd5);
        chk("n6_sel5.sel_err", {31'd0, sel_err6}, 32'd0);
        sel = 3'd7;
        step();
        en = 1'b0;
        step();
        chk("n6_en0.sel_err",  {31'd0, sel_err6}, 32'd0);
        chk("n6_en0.y_valid",  {31'd0, y_valid6}, 32'd0);
        chk("n6_en0.ch",       {29'd0, ch6},      32'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
